spsr_frame_ctrl: RTL and testbench
==================================

SPSR_FRAME_CTRL -- requirements
Module: spsr_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 4: data bits per frame, legal range 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  frame-sync pulse; begins a new frame.
REQ-005 SHALL have port din  input  1  serial data bit.
REQ-006 SHALL have port din_vld  input  1  din is valid this cycle.
REQ-007 SHALL have port out_rdy  input  1  consumer accepts dout this cycle.
REQ-008 SHALL have port dout  output  FRAME_BITS  assembled parallel frame.
REQ-009 SHALL have port dout_vld  output  1  dout holds a complete frame.
REQ-010 SHALL have port shift_en  output  1  high in every cycle a bit is shifted in.
REQ-011 SHALL have port busy  output  1  high while state is not IDLE.
REQ-012 SHALL have port bit_cnt  output  5  bits received in the current frame.
REQ-013 SHALL have port overrun  output  1  sticky: a bit arrived while a frame was held.
REQ-014 SHALL have port par_err  output  1  parity failure on the held frame.

Function
REQ-015 SHALL implement states IDLE, SHIFT, PARITY, HOLD; PARITY is reachable only with the macro of REQ-029 defined.
REQ-016 IDLE: start=1 -> SHIFT with bit_cnt=0; din_vld is ignored and shift_en=0.
REQ-017 SHIFT: din_vld=1 -> shift_en=1, dout <= {dout[FRAME_BITS-2:0], din}, bit_cnt+1; first bit received ends in dout[FRAME_BITS-1].
REQ-018 SHIFT: din_vld=0 -> no shift, bit_cnt holds; no timeout.
REQ-019 SHIFT: on the edge sampling bit FRAME_BITS -> HOLD (or PARITY if enabled); dout_vld=1 the following cycle (latency 1 cycle from last bit).
REQ-020 HOLD: dout and dout_vld stable until out_rdy=1; out_rdy=1 -> IDLE, dout_vld=0 next cycle.
REQ-021 HOLD: din_vld=1 -> bit discarded, shift_en=0, overrun set to 1 and held until reset.
REQ-022 HOLD with out_rdy=1 and start=1 same cycle -> frame accepted and next state SHIFT, bit_cnt=0 (back-to-back frames, no idle cycle).
REQ-023 SHIFT with start=1 -> partial frame discarded, bit_cnt=0, dout cleared, stay SHIFT; start takes priority over din_vld that cycle.
REQ-024 HOLD with start=1 and out_rdy=0 -> start ignored.
REQ-025 out_rdy outside HOLD SHALL have no effect.
REQ-026 bit_cnt SHALL never exceed FRAME_BITS (FRAME_BITS+1 with parity); returns to 0 on entry to IDLE.

Reset
REQ-027 rst=1 on a rising edge SHALL force state IDLE, dout=0, dout_vld=0, shift_en=0, busy=0, bit_cnt=0, overrun=0, par_err=0.
REQ-028 rst SHALL override start, din_vld, out_rdy in the same cycle; a frame in progress or held is discarded.

Configuration
REQ-029 SHALL compile an even-parity trailer when macro SPSR_FRAME_CTRL_PARITY_EN is defined.
REQ-030 With SPSR_FRAME_CTRL_PARITY_EN: after FRAME_BITS data bits go to PARITY; next valid bit is parity, not shifted into dout, shift_en=0, bit_cnt=FRAME_BITS+1; then HOLD with par_err = XOR(dout, parity bit); par_err clears on leaving HOLD.
REQ-031 Without SPSR_FRAME_CTRL_PARITY_EN: no PARITY state, par_err tied 0, frame is FRAME_BITS bits only.

Verification
REQ-032 rst, start, din=1,0,1,1 with din_vld=1 each cycle, out_rdy=0 -> dout=4'b1011, dout_vld=1 one cycle after 4th bit, shift_en high exactly 4 cycles.
REQ-033 Same frame with din_vld gapped (1,0,0,1,1,0,1) -> identical dout=4'b1011; bit_cnt holds during gaps.
REQ-034 HOLD with dout=4'b1011, din_vld=1 for 2 cycles -> dout unchanged, overrun=1 and stays 1 after out_rdy; cleared only by rst.
REQ-035 HOLD, out_rdy=1 and start=1 same cycle, then bits 0,1,1,0 -> second frame dout=4'b0110, no IDLE cycle between frames.
REQ-036 After 2 bits, start=1 -> bit_cnt=0; then 1,1,0,0 -> dout=4'b1100; rst asserted in HOLD -> all outputs 0 next cycle.
REQ-037 With SPSR_FRAME_CTRL_PARITY_EN: data 1,0,1,1 plus parity 1 -> par_err=0; parity 0 -> par_err=1; dout=4'b1011 in both.

Source files
------------

// File: rtl/spsr_frame_ctrl.sv
// Serial-to-parallel frame assembler with hold/handshake, overrun flag and
// optional even-parity trailer (enable with macro SPSR_FRAME_CTRL_PARITY_EN).
module spsr_frame_ctrl #(
    parameter int FRAME_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  din,
    input  logic                  din_vld,
    input  logic                  out_rdy,
    output logic [FRAME_BITS-1:0] dout,
    output logic                  dout_vld,
    output logic                  shift_en,
    output logic                  busy,
    output logic [4:0]            bit_cnt,
    output logic                  overrun,
    output logic                  par_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Count value present while the final data bit of a frame is being sampled
    localparam logic [4:0] LAST_CNT = 5'(FRAME_BITS - 1);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [FRAME_BITS-1:0]   dout_r;
    logic                    dout_vld_r;
    logic                    busy_r;
    logic [4:0]              bit_cnt_r;
    logic                    overrun_r;
    logic                    shift_en_s;

`ifdef SPSR_FRAME_CTRL_PARITY_EN
    logic                    par_err_r;

    // Even parity over data plus trailer: a nonzero result flags an error
    function automatic logic even_par_err(input logic [FRAME_BITS-1:0] data, input logic par_bit);
        return (^data) ^ par_bit;
    endfunction
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (start) begin
                    state_nxt_s = SHIFT;
                end else if (din_vld && (bit_cnt_r == LAST_CNT)) begin
`ifdef SPSR_FRAME_CTRL_PARITY_EN
                    state_nxt_s = PARITY;
`else
                    state_nxt_s = HOLD;
`endif
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
`ifdef SPSR_FRAME_CTRL_PARITY_EN
            PARITY: begin
                if (start) begin
                    state_nxt_s = SHIFT;
                end else if (din_vld) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
`endif
            HOLD: begin
                if (out_rdy && start) begin
                    state_nxt_s = SHIFT;
                end else if (out_rdy) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output logic: shift strobe, suppressed by a restart and by reset
    always_comb begin
        shift_en_s = 1'b0;
        if ((state_r == SHIFT) && din_vld && !start && !rst) begin
            shift_en_s = 1'b1;
        end else begin
            shift_en_s = 1'b0;
        end
    end

    // Datapath: shift register, bit counter, status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r     <= '0;
            dout_vld_r <= 1'b0;
            busy_r     <= 1'b0;
            bit_cnt_r  <= 5'd0;
            overrun_r  <= 1'b0;
`ifdef SPSR_FRAME_CTRL_PARITY_EN
            par_err_r  <= 1'b0;
`endif
        end else begin
            dout_vld_r <= (state_nxt_s == HOLD);
            busy_r     <= (state_nxt_s != IDLE);
            case (state_r)
                IDLE: begin
                    bit_cnt_r <= 5'd0;
                    if (start) begin
                        dout_r <= '0;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        dout_r    <= '0;
                        bit_cnt_r <= 5'd0;
                    end else if (din_vld) begin
                        dout_r    <= {dout_r[FRAME_BITS-2:0], din};
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                    end
                end
`ifdef SPSR_FRAME_CTRL_PARITY_EN
                PARITY: begin
                    if (start) begin
                        dout_r    <= '0;
                        bit_cnt_r <= 5'd0;
                    end else if (din_vld) begin
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                        par_err_r <= even_par_err(dout_r, din);
                    end
                end
`endif
                HOLD: begin
                    if (din_vld) begin
                        overrun_r <= 1'b1;
                    end
                    if (out_rdy) begin
                        bit_cnt_r <= 5'd0;
`ifdef SPSR_FRAME_CTRL_PARITY_EN
                        par_err_r <= 1'b0;
`endif
                        if (start) begin
                            dout_r <= '0;
                        end
                    end
                end
                default: begin
                    bit_cnt_r <= 5'd0;
                end
            endcase
        end
    end

    assign dout     = dout_r;
    assign dout_vld = dout_vld_r;
    assign busy     = busy_r;
    assign bit_cnt  = bit_cnt_r;
    assign overrun  = overrun_r;
    assign shift_en = shift_en_s;
`ifdef SPSR_FRAME_CTRL_PARITY_EN
    assign par_err  = par_err_r;
`else
    assign par_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spsr_frame_ctrl.sv
// Directed bench for spsr_frame_ctrl; expected frames go through a scoreboard queue.
module tb_spsr_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       din = 1'b0;
    logic       din_vld = 1'b0;
    logic       out_rdy = 1'b0;
    logic [3:0] dout;
    logic       dout_vld;
    logic       shift_en;
    logic       busy;
    logic [4:0] bit_cnt;
    logic       overrun;
    logic       par_err;

    int n_cmp = 0;
    int n_err = 0;
    int sh_cnt = 0;
    logic [4:0] exp_q[$];   // {expected par_err, expected dout}

    spsr_frame_ctrl #(.FRAME_BITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .din_vld(din_vld),
        .out_rdy(out_rdy), .dout(dout), .dout_vld(dout_vld), .shift_en(shift_en),
        .busy(busy), .bit_cnt(bit_cnt), .overrun(overrun), .par_err(par_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check shift_en mid-cycle, release after the edge
    task automatic tick(input logic st, input logic d, input logic v, input logic r, input logic exp_sh);
        start = st; din = d; din_vld = v; out_rdy = r;
        @(negedge clk);
        chk("shift_en", {31'd0, shift_en}, {31'd0, exp_sh});
        if (shift_en) sh_cnt++;
        @(posedge clk); #1;
        start = 1'b0; din_vld = 1'b0; out_rdy = 1'b0;
    endtask

    // Send 4 data bits MSB first (plus parity trailer when enabled) and queue the result
    task automatic send4(input logic [3:0] v, input logic par_bit);
        for (int i = 3; i >= 0; i--) tick(1'b0, v[i], 1'b1, 1'b0, 1'b1);
`ifdef SPSR_FRAME_CTRL_PARITY_EN
        chk("bit_cnt_pre_par", {27'd0, bit_cnt}, 32'd4);
        tick(1'b0, par_bit, 1'b1, 1'b0, 1'b0);
        exp_q.push_back({(^v) ^ par_bit, v});
`else
        exp_q.push_back({1'b0, v});
`endif
    endtask

    // Wait (bounded) for dout_vld, then pop and compare against the scoreboard
    task automatic expect_frame(input string tag);
        int n;
        logic [4:0] e;
        n = 0;
        while (!dout_vld && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 32'd0);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_dout"}, {28'd0, dout}, {28'd0, e[3:0]});
            chk({tag, "_par_err"}, {31'd0, par_err}, {31'd0, e[4]});
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {dout, dout_vld, shift_en, busy, bit_cnt, overrun, par_err}, 32'd0);
    endtask

    initial begin
        // Reset; rst overrides start/din_vld in the same cycle
        start = 1'b1; din_vld = 1'b1; din = 1'b1; out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; din_vld = 1'b0; out_rdy = 1'b0;
        chk_all_zero("reset");

        // Basic frame 1011, contiguous bits
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("bit_cnt_after_start", {27'd0, bit_cnt}, 32'd0);
        sh_cnt = 0;
        send4(4'b1011, 1'b1);
        expect_frame("f1011");
        chk("shift_en_count", sh_cnt, 32'd4);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hold_stable", {27'd0, dout_vld, dout}, {27'd0, 1'b1, 4'b1011});
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("release", {25'd0, dout_vld, busy, bit_cnt}, 32'd0);

        // out_rdy in IDLE has no effect, din_vld ignored
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("idle_ignore", {26'd0, busy, dout_vld, bit_cnt}, 32'd0);

        // Gapped frame: 1,gap,gap,0,1,gap,1
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("gap_bit_cnt", {27'd0, bit_cnt}, 32'd1);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("gap_bit_cnt2", {27'd0, bit_cnt}, 32'd3);
        chk("gap_no_vld", {31'd0, dout_vld}, 32'd0);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
`ifdef SPSR_FRAME_CTRL_PARITY_EN
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_q.push_back({1'b0, 4'b1011});
`else
        exp_q.push_back({1'b0, 4'b1011});
`endif
        expect_frame("gapped");

        // Overrun: bits during HOLD are discarded, flag is sticky
        chk("overrun_pre", {31'd0, overrun}, 32'd0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("overrun_dout", {27'd0, dout_vld, dout}, {27'd0, 1'b1, 4'b1011});
        chk("overrun_set", {31'd0, overrun}, 32'd1);

        // Back-to-back: accept and restart in the same cycle
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_state", {26'd0, dout_vld, bit_cnt}, 32'd0);
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);
        send4(4'b0110, 1'b0);
        expect_frame("f0110");
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Restart mid-frame: start wins over din_vld
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("partial_cnt", {27'd0, bit_cnt}, 32'd2);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("restart_cnt", {27'd0, bit_cnt}, 32'd0);
        chk("restart_dout", {28'd0, dout}, 32'd0);
        send4(4'b1100, 1'b0);
        expect_frame("f1100");
        // HOLD ignores start without out_rdy
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hold_ignore_start", {27'd0, dout_vld, dout}, {27'd0, 1'b1, 4'b1100});

`ifdef SPSR_FRAME_CTRL_PARITY_EN
        // Bad parity trailer
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send4(4'b1011, 1'b0);
        expect_frame("bad_par");
`endif

        // Reset in HOLD clears everything including overrun
        rst = 1'b1; out_rdy = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_rdy = 1'b0; start = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_hold");
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
